// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-rejecting start detect, optional parity,
// valid/ready holding register with overrun. UART_RX_MAJORITY_EN enables 2-of-3 bit voting.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int DISP_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [DISP_BITS-1:0] number_data_sig
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // The start decision sits MAJ clocks past mid-bit; later bits inherit that offset.
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_PT   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic                   r_rx_p0, r_rx_p1, r_rx_p2;
  logic                   w_fall;
  logic                   w_bit;

  // Synchroniser (p0, p1) and edge-detect history (p2); rx_s is r_rx_p1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_p0 <= 1'b1;
      r_rx_p1 <= 1'b1;
      r_rx_p2 <= 1'b1;
    end else begin
      r_rx_p0 <= rx_pin_in;
      r_rx_p1 <= r_rx_p0;
      r_rx_p2 <= r_rx_p1;
    end
  end

  assign w_fall = r_rx_p2 & ~r_rx_p1;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]    r_maj;
  logic [CW-1:0] w_pt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_pt  = (r_state == START) ? START_PT : BIT_PT;
  assign w_bit = maj3(r_maj[0], r_maj[1], r_rx_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_maj <= 2'b11;
    end else begin
      if (r_cnt == w_pt - CW'(2)) r_maj[0] <= r_rx_p1;
      if (r_cnt == w_pt - CW'(1)) r_maj[1] <= r_rx_p1;
    end
  end
`else
  assign w_bit = r_rx_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_par_err       <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      frame_err       <= 1'b0;
      parity_err      <= 1'b0;
      overrun         <= 1'b0;
      busy            <= 1'b0;
      number_data_sig <= '0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      r_cnt      <= r_cnt + CW'(1);
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_par_err <= 1'b0;
          if (w_fall) begin
            r_state <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == START_PT) begin
            r_cnt <= '0;
            r_idx <= '0;
            if (!w_bit) begin
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (r_cnt == BIT_PT) begin
            r_cnt   <= '0;
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + IW'(1);
            if (r_idx == IW'(DATA_BITS - 1))
              r_state <= (PARITY_MODE != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (r_cnt == BIT_PT) begin
            r_cnt     <= '0;
            // Odd mode wants data^parity == 1, even mode wants 0
            r_par_err <= (^r_shift) ^ w_bit ^ (PARITY_MODE == 1);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (r_cnt == BIT_PT) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
            if (!w_bit) begin
              frame_err <= 1'b1;
            end else if (r_par_err) begin
              parity_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data         <= r_shift;
              rx_valid        <= 1'b1;
              number_data_sig <= r_shift[DISP_BITS-1:0];
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed cases plus randomized frames checked against a
// frame-level outcome model, on a no-parity instance and an even-parity instance.
module tb_uart_rx_param;
  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic rst, rx0, rx2, rdy0, rdy2;
  logic [7:0] d0, d2;
  logic [3:0] n0, n2;
  logic v0, fe0, pe0, ov0, b0;
  logic v2, fe2, pe2, ov2, b2;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .DISP_BITS(4)) dut0 (
    .clk(clk), .rst(rst), .rx_pin_in(rx0), .rx_ready(rdy0), .rx_data(d0), .rx_valid(v0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0), .number_data_sig(n0));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .DISP_BITS(4)) dut2 (
    .clk(clk), .rst(rst), .rx_pin_in(rx2), .rx_ready(rdy2), .rx_data(d2), .rx_valid(v2),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(b2), .number_data_sig(n2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_load[2], n_fe[2], n_pe[2], n_ov[2], n_vhi[2], n_busy[2], t_rise[2], t_start[2];
  bit [1:0] vq;
  logic       mvalid[2];
  logic [7:0] mdata[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts rx_valid rises, pulses and busy/valid-high cycles per instance
  always @(negedge clk) begin
    logic [1:0] wv, wf, wp, wo, wb;
    wv = {v2, v0}; wf = {fe2, fe0}; wp = {pe2, pe0}; wo = {ov2, ov0}; wb = {b2, b0};
    for (int s = 0; s < 2; s++) begin
      if (wv[s] === 1'b1 && !vq[s]) begin n_load[s]++; t_rise[s] = cyc; end
      if (wv[s] === 1'b1) n_vhi[s]++;
      if (wf[s] === 1'b1) n_fe[s]++;
      if (wp[s] === 1'b1) n_pe[s]++;
      if (wo[s] === 1'b1) n_ov[s]++;
      if (wb[s] === 1'b1) n_busy[s]++;
      vq[s] = (wv[s] === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic drive(input int s, input logic v);
    if (s == 0) rx0 = v; else rx2 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int s, input logic [7:0] d, input logic pb, input logic has_par,
                      input logic stop, input int idle);
    t_start[s] = cyc;
    drive(s, 1'b0);
    for (int i = 0; i < 8; i++) drive(s, d[i]);
    if (has_par) drive(s, pb);
    drive(s, stop);
    for (int i = 0; i < idle; i++) drive(s, 1'b1);
  endtask

  initial begin
    int l, f, p, o, vh, bz;
    rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1; rdy0 = 1'b0; rdy2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", {v2, v0}, 0);
    chk("rst_data", {d2, d0}, 0);
    chk("rst_disp", {n2, n0}, 0);
    chk("rst_busy", {b2, b0}, 0);
    chk("rst_flags", {fe0, pe0, ov0, fe2, pe2, ov2}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Quarter-bit glitch on an idle line
    l = n_load[0]; f = n_fe[0] + n_pe[0] + n_ov[0]; bz = n_busy[0];
    rx0 = 1'b0; repeat (CPB / 4) @(negedge clk); rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy_cycles", n_busy[0] - bz, CPB / 2 + MAJ);
    chk("glitch_no_load", n_load[0] - l, 0);
    chk("glitch_no_flags", n_fe[0] + n_pe[0] + n_ov[0] - f, 0);
    chk("glitch_idle", b0, 0);

    // 0xA5 with consumer ready
    rdy0 = 1'b1;
    l = n_load[0]; f = n_fe[0] + n_pe[0] + n_ov[0]; vh = n_vhi[0];
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 2);
    chk("a5_load", n_load[0] - l, 1);
    chk("a5_valid_1cyc", n_vhi[0] - vh, 1);
    chk("a5_data", d0, 8'hA5);
    chk("a5_disp", n0, 4'h5);
    chk("a5_no_flags", n_fe[0] + n_pe[0] + n_ov[0] - f, 0);
    chk("a5_latency", t_rise[0] - t_start[0], 155 + MAJ);

    // Stop bit low, then a good word
    l = n_load[0]; f = n_fe[0]; p = n_pe[0] + n_ov[0];
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 2);
    chk("ferr_pulse", n_fe[0] - f, 1);
    chk("ferr_no_load", n_load[0] - l, 0);
    chk("ferr_no_other", n_pe[0] + n_ov[0] - p, 0);
    send(0, 8'h12, 1'b0, 1'b0, 1'b1, 2);
    chk("after_ferr_data", d0, 8'h12);

    // Back-to-back with consumer stalled
    rdy0 = 1'b0;
    l = n_load[0]; o = n_ov[0];
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1, 2);
    chk("ovr_data_kept", d0, 8'h3C);
    chk("ovr_valid", v0, 1);
    chk("ovr_pulse", n_ov[0] - o, 1);
    chk("ovr_one_load", n_load[0] - l, 1);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", v0, 0);
    chk("ovr_disp", n0, 4'hC);

    // Even parity: 0x07 needs parity bit 1
    rdy2 = 1'b1;
    l = n_load[1]; p = n_pe[1]; f = n_fe[1];
    send(1, 8'h07, 1'b0, 1'b1, 1'b1, 2);
    chk("perr_pulse", n_pe[1] - p, 1);
    chk("perr_no_load", n_load[1] - l, 0);
    chk("perr_no_ferr", n_fe[1] - f, 0);
    chk("perr_valid_low", v2, 0);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, 2);
    chk("par_ok_data", d2, 8'h07);
    chk("par_ok_load", n_load[1] - l, 1);

    // Reset during DATA (pulsed while line is high so no spurious edge follows)
    rdy0 = 1'b0;
    l = n_load[0]; f = n_fe[0];
    drive(0, 1'b0); drive(0, 1'b0);
    rx0 = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", b0, 0);
    chk("mid_rst_outs", {v0, d0, n0, fe0, pe0, ov0}, 0);
    chk("mid_rst_data2", d2, 0);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("mid_rst_no_frame", n_load[0] - l + n_fe[0] - f, 0);
    rdy0 = 1'b1;
    send(0, 8'h9E, 1'b0, 1'b0, 1'b1, 2);
    chk("post_rst_data", d0, 8'h9E);

    // Randomized frames vs frame-level outcome model
    mvalid[0] = 1'b0; mvalid[1] = 1'b0;
    mdata[0] = 8'h9E; mdata[1] = 8'h00;
    for (int k = 0; k < 24; k++) begin
      int s, el, ef, ep, eo;
      logic [7:0] d;
      logic st, rd, pok, pb;
      s = k % 2;
      d = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      rd = 1'($urandom_range(0, 1));
      pok = ($urandom_range(0, 3) != 0);
      pb = (^d) ^ !pok;
      if (s == 0) rdy0 = rd; else rdy2 = rd;
      if (rd) mvalid[s] = 1'b0;
      l = n_load[s]; f = n_fe[s]; p = n_pe[s]; o = n_ov[s];
      send(s, d, pb, (s == 1), st, 2);
      el = 0; ef = 0; ep = 0; eo = 0;
      if (!st) ef = 1;
      else if (s == 1 && !pok) ep = 1;
      else if (mvalid[s] && !rd) eo = 1;
      else begin el = 1; mdata[s] = d; mvalid[s] = !rd; end
      chk($sformatf("rnd%0d_load", k), n_load[s] - l, el);
      chk($sformatf("rnd%0d_ferr", k), n_fe[s] - f, ef);
      chk($sformatf("rnd%0d_perr", k), n_pe[s] - p, ep);
      chk($sformatf("rnd%0d_ovr", k), n_ov[s] - o, eo);
      chk($sformatf("rnd%0d_valid", k), (s == 0) ? v0 : v2, mvalid[s]);
      chk($sformatf("rnd%0d_data", k), (s == 0) ? d0 : d2, mdata[s]);
      chk($sformatf("rnd%0d_disp", k), (s == 0) ? n0 : n2, mdata[s][3:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver for the serial port subsystem. It supersedes the fixed 8N1 receive-plus-test pairing.
- Configurable data width, parity mode and baud divisor.
- Glitch-rejecting start detection.
- Frame and parity error reporting.
- Valid/ready output handshake with overrun detection.
- Persistent display nibble of the last good byte, which drives LED/7-seg test logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period; >= 8 (434 = 115200 baud at 50 MHz)
DATA_BITS, 8, data bits per frame; 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
DISP_BITS, 4, width of the display output, <= DATA_BITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_pin_in  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch
overrun  out  1  one-cycle pulse: good word dropped because the holding register was full
busy  out  1  high whenever the FSM is not in IDLE
number_data_sig  out  DISP_BITS  rx_data[DISP_BITS-1:0] of the last accepted word; holds value

Behaviour:
- Reset is synchronous, active-high. It returns the FSM to IDLE from any state and aborts any frame in progress; the partial word is discarded. Reset values:
  - rx_data, rx_valid, frame_err, parity_err, overrun, busy, number_data_sig = 0
  - synchroniser flops = 1
- Input path: 2-flop synchroniser on rx_pin_in. All logic uses the synchronised value rx_s. Edge detect compares rx_s with its previous value.
- Bit timer: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge of rx_s, go to START.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample. If rx_s=0, go to DATA with bit index 0. If rx_s=1, treat as a glitch and return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rx_s in LSB-first. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: sample at mid-bit and compare against XOR of the data bits. Odd mode expects data XOR parity = 1; even mode expects it = 0. Store the mismatch result, then go to STOP.
  - STOP: sample at mid-bit, then go to IDLE on the next cycle. A new start edge is accepted from that cycle onward, so back-to-back frames are supported.
- Frame completion, evaluated at the STOP sample clock edge; outputs change one cycle later:
  - Stop bit = 0: frame_err pulses and the word is discarded. This takes precedence over parity; parity_err is not pulsed.
  - Stop bit = 1 with a parity mismatch: parity_err pulses and the word is discarded.
  - Good word with the holding register free (rx_valid=0, or rx_valid && rx_ready in the same cycle): load rx_data, set rx_valid=1, update number_data_sig.
  - Good word with rx_valid=1 and rx_ready=0: overrun pulses. The old rx_data is retained and the new word is dropped.
- Handshake:
  - rx_valid stays high until the first cycle with rx_ready=1, then clears on the next edge unless a new word is loaded in that same cycle.
  - rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 1 clk after the mid-stop-bit sample. That is about 2 (sync) + (1.5 + DATA_BITS + P) × CLKS_PER_BIT + 1 clk after the line falling edge, where P = 1 with parity, 0 without.
- Line held low (break): the frame completes with frame_err. The FSM then waits in IDLE for a rising edge followed by a falling edge before the next frame; no repeated errors.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of rx_s at counts mid-1, mid and mid+1. The decision is taken at count mid+1, which adds 1 clk of latency.
- Not defined: single sample at mid.
- Behaviour is otherwise identical in both builds.

Test Plan:
CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=0:
- Send 0xA5, rx_ready=1 → rx_valid high exactly 1 cycle, rx_data=0xA5, number_data_sig=0x5, no error pulses.
- 0.25-bit low glitch on an idle line → returns to IDLE; no rx_valid, no flags; busy pulses only during START.
- Send 0x3C then 0x81 back-to-back with rx_ready=0 → rx_data stays 0x3C, overrun pulses once. Then raise rx_ready → rx_valid drops and number_data_sig=0xC.

Other configurations:
- PARITY_MODE=2: send 0x07 with parity bit 0 (wrong) → parity_err pulse, rx_valid stays 0. Resend with parity 1 → rx_data=0x07.
- Send 0x55 with stop bit 0 → frame_err pulse only. Then a valid 0x12 → rx_data=0x12.
- Assert rst mid-DATA for 1 cycle → busy=0 next cycle, all outputs 0. A following frame of 0x9E is received correctly.
- UART_RX_MAJORITY_EN build: 1-clk inverted spike at each data-bit centre of 0x6B → rx_data=0x6B.
